// File: rtl/cart_mem_arbiter.sv
// Fixed-priority arbiter sharing one cartridge memory port among cart reads, loader writes and
// save accesses. Optional one-entry prefetch cache is enabled with `define CART_PREFETCH_EN.
module cart_mem_arbiter #(
  parameter int unsigned ADDR_W  = 25,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              cart_req,
  input  logic [ADDR_W-1:0] cart_addr,
  output logic [7:0]        cart_data,
  output logic              cart_valid,
  output logic              cart_overrun,
  input  logic              ldr_req,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [7:0]        ldr_wdata,
  output logic              ldr_ack,
  input  logic              save_req,
  input  logic              save_we,
  input  logic [ADDR_W-1:0] save_addr,
  input  logic [7:0]        save_wdata,
  output logic [7:0]        save_rdata,
  output logic              save_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              busy
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StCart     = 3'd1;
  localparam logic [2:0] StLdr      = 3'd2;
  localparam logic [2:0] StSave     = 3'd3;
`ifdef CART_PREFETCH_EN
  localparam logic [2:0] StPrefetch = 3'd4;
`endif

  // Abort fires on the last of TIMEOUT consecutive ack-less cycles in a busy state.
  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              overrun_q, overrun_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [7:0]        cart_data_q, cart_data_d;
  logic              cart_valid_q, cart_valid_d;
  logic              ldr_ack_q, ldr_ack_d;
  logic              save_ack_q, save_ack_d;
  logic [7:0]        save_rdata_q, save_rdata_d;
  logic [7:0]        fin_data;

`ifdef CART_PREFETCH_EN
  logic              pf_want_q, pf_want_d;
  logic [ADDR_W-1:0] pf_addr_q, pf_addr_d;
  logic              cache_valid_q, cache_valid_d;
  logic [ADDR_W-1:0] cache_tag_q, cache_tag_d;
  logic [7:0]        cache_data_q, cache_data_d;
  logic              cart_hit;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    pend_addr_d  = pend_addr_q;
    overrun_d    = overrun_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cart_data_d  = cart_data_q;
    cart_valid_d = 1'b0;
    ldr_ack_d    = 1'b0;
    save_ack_d   = 1'b0;
    save_rdata_d = save_rdata_q;
    fin_data     = mem_ack ? mem_rdata : 8'hFF;
`ifdef CART_PREFETCH_EN
    pf_want_d     = pf_want_q;
    pf_addr_d     = pf_addr_q;
    cache_valid_d = cache_valid_q;
    cache_tag_d   = cache_tag_q;
    cache_data_d  = cache_data_q;
    // A CART completion would collide with the hit pulse, so hits are served elsewhere only.
    cart_hit      = cache_valid_q && (cart_addr == cache_tag_q) && (state_q != StCart);
`endif

`ifdef CART_PREFETCH_EN
    if (cart_req && cart_hit) begin
      cart_valid_d = 1'b1;
      cart_data_d  = cache_data_q;
    end else if (cart_req) begin
`else
    if (cart_req) begin
`endif
      if (pend_q) overrun_d = 1'b1;
      pend_d      = 1'b1;
      pend_addr_d = cart_addr;
    end

    if (state_q == StIdle) begin
      cnt_d = 8'd0;
      // pend_d already folds in a cart_req arriving this cycle.
      if (pend_d) begin
        state_d     = StCart;
        pend_d      = 1'b0;
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b0;
        mem_addr_d  = pend_addr_d;
        mem_wdata_d = 8'd0;
      end else if (ldr_req) begin
        state_d     = StLdr;
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = ldr_addr;
        mem_wdata_d = ldr_wdata;
`ifdef CART_PREFETCH_EN
        if (ldr_addr == cache_tag_q) cache_valid_d = 1'b0;
`endif
      end else if (save_req) begin
        state_d     = StSave;
        mem_req_d   = 1'b1;
        mem_we_d    = save_we;
        mem_addr_d  = save_addr;
        mem_wdata_d = save_wdata;
`ifdef CART_PREFETCH_EN
        if (save_we && (save_addr == cache_tag_q)) cache_valid_d = 1'b0;
`endif
      end
`ifdef CART_PREFETCH_EN
      else if (pf_want_q) begin
        state_d     = StPrefetch;
        pf_want_d   = 1'b0;
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b0;
        mem_addr_d  = pf_addr_q;
        mem_wdata_d = 8'd0;
      end
`endif
    end else begin
      if (mem_ack || (cnt_q == CntLast)) begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
        if (state_q == StCart) begin
          cart_valid_d = 1'b1;
          cart_data_d  = fin_data;
`ifdef CART_PREFETCH_EN
          if (mem_ack) begin
            pf_want_d = 1'b1;
            pf_addr_d = mem_addr_q + ADDR_W'(1);
          end
`endif
        end
        if (state_q == StLdr) ldr_ack_d = 1'b1;
        if (state_q == StSave) begin
          save_ack_d = 1'b1;
          if (!mem_we_q) save_rdata_d = fin_data;
        end
`ifdef CART_PREFETCH_EN
        if ((state_q == StPrefetch) && mem_ack) begin
          cache_valid_d = 1'b1;
          cache_tag_d   = mem_addr_q;
          cache_data_d  = mem_rdata;
        end
`endif
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= 8'd0;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      overrun_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 8'd0;
      cart_data_q  <= 8'd0;
      cart_valid_q <= 1'b0;
      ldr_ack_q    <= 1'b0;
      save_ack_q   <= 1'b0;
      save_rdata_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      pend_addr_q  <= pend_addr_d;
      overrun_q    <= overrun_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cart_data_q  <= cart_data_d;
      cart_valid_q <= cart_valid_d;
      ldr_ack_q    <= ldr_ack_d;
      save_ack_q   <= save_ack_d;
      save_rdata_q <= save_rdata_d;
    end
  end

`ifdef CART_PREFETCH_EN
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pf_want_q     <= 1'b0;
      pf_addr_q     <= '0;
      cache_valid_q <= 1'b0;
      cache_tag_q   <= '0;
      cache_data_q  <= 8'd0;
    end else begin
      pf_want_q     <= pf_want_d;
      pf_addr_q     <= pf_addr_d;
      cache_valid_q <= cache_valid_d;
      cache_tag_q   <= cache_tag_d;
      cache_data_q  <= cache_data_d;
    end
  end
`endif

  assign cart_data    = cart_data_q;
  assign cart_valid   = cart_valid_q;
  assign cart_overrun = overrun_q;
  assign ldr_ack      = ldr_ack_q;
  assign save_ack     = save_ack_q;
  assign save_rdata   = save_rdata_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Directed bench for cart_mem_arbiter: a transaction-level model checked every cycle plus
// literal expectations at key points of each scenario.
module tb_cart_mem_arbiter;
  localparam int unsigned ADDR_W  = 25;
  localparam int unsigned TIMEOUT = 15;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic              cart_req;
  logic [ADDR_W-1:0] cart_addr;
  logic [7:0]        cart_data;
  logic              cart_valid;
  logic              cart_overrun;
  logic              ldr_req;
  logic [ADDR_W-1:0] ldr_addr;
  logic [7:0]        ldr_wdata;
  logic              ldr_ack;
  logic              save_req;
  logic              save_we;
  logic [ADDR_W-1:0] save_addr;
  logic [7:0]        save_wdata;
  logic [7:0]        save_rdata;
  logic              save_ack;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;
  logic              busy;

  always #5 clk_sys = ~clk_sys;

  cart_mem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .cart_req(cart_req), .cart_addr(cart_addr), .cart_data(cart_data),
    .cart_valid(cart_valid), .cart_overrun(cart_overrun),
    .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack),
    .save_req(save_req), .save_we(save_we), .save_addr(save_addr), .save_wdata(save_wdata),
    .save_rdata(save_rdata), .save_ack(save_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic peek();
    @(negedge clk_sys);
  endtask

`ifndef CART_PREFETCH_EN
  // Model: owner 0 = none, 1 = cart, 2 = loader, 3 = save.
  bit              m_live;
  int              m_owner, m_cycles;
  bit              m_pend, m_overrun, m_we, m_cv, m_la, m_sa;
  logic [ADDR_W-1:0] m_paddr, m_addr;
  logic [7:0]      m_wdata, m_cart_data, m_save_rdata, m_fin;

  initial begin : model
    m_live = 1'b0;
    forever begin
      @(posedge clk_sys);
      if (reset) begin
        m_live = 1'b1; m_owner = 0; m_cycles = 0; m_pend = 1'b0; m_paddr = '0;
        m_overrun = 1'b0; m_addr = '0; m_we = 1'b0; m_wdata = 8'd0;
        m_cart_data = 8'd0; m_save_rdata = 8'd0; m_cv = 1'b0; m_la = 1'b0; m_sa = 1'b0;
      end else if (m_live) begin
        m_cv = 1'b0; m_la = 1'b0; m_sa = 1'b0;
        if (cart_req) begin
          if (m_pend) m_overrun = 1'b1;
          m_pend  = 1'b1;
          m_paddr = cart_addr;
        end
        if (m_owner == 0) begin
          m_cycles = 0;
          if (m_pend) begin
            m_owner = 1; m_addr = m_paddr; m_we = 1'b0; m_pend = 1'b0;
          end else if (ldr_req) begin
            m_owner = 2; m_addr = ldr_addr; m_we = 1'b1; m_wdata = ldr_wdata;
          end else if (save_req) begin
            m_owner = 3; m_addr = save_addr; m_we = save_we; m_wdata = save_wdata;
          end
        end else begin
          m_cycles++;
          if (mem_ack || m_cycles == TIMEOUT) begin
            m_fin = mem_ack ? mem_rdata : 8'hFF;
            if (m_owner == 1) begin
              m_cv = 1'b1; m_cart_data = m_fin;
            end else if (m_owner == 2) begin
              m_la = 1'b1;
            end else begin
              m_sa = 1'b1;
              if (!m_we) m_save_rdata = m_fin;
            end
            m_owner = 0;
          end
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk_sys);
      if (m_live) begin
        chk("model mem_req", {31'd0, mem_req}, {31'd0, m_owner != 0});
        chk("model busy", {31'd0, busy}, {31'd0, m_owner != 0});
        chk("model cart_valid", {31'd0, cart_valid}, {31'd0, m_cv});
        chk("model ldr_ack", {31'd0, ldr_ack}, {31'd0, m_la});
        chk("model save_ack", {31'd0, save_ack}, {31'd0, m_sa});
        chk("model cart_overrun", {31'd0, cart_overrun}, {31'd0, m_overrun});
        chk("model cart_data", {24'd0, cart_data}, {24'd0, m_cart_data});
        chk("model save_rdata", {24'd0, save_rdata}, {24'd0, m_save_rdata});
        if (m_owner != 0) begin
          chk("model mem_addr", {7'd0, mem_addr}, {7'd0, m_addr});
          chk("model mem_we", {31'd0, mem_we}, {31'd0, m_we});
          if (m_we) chk("model mem_wdata", {24'd0, mem_wdata}, {24'd0, m_wdata});
        end
      end
    end
  end
`endif

  initial begin : stim
    reset = 1'b1; cart_req = 1'b0; cart_addr = '0; ldr_req = 1'b0; ldr_addr = '0;
    ldr_wdata = 8'd0; save_req = 1'b0; save_we = 1'b0; save_addr = '0; save_wdata = 8'd0;
    mem_rdata = 8'd0; mem_ack = 1'b0;
    step(); step();
    reset = 1'b0;
    peek();
    chk("reset mem_req", {31'd0, mem_req}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset cart_valid", {31'd0, cart_valid}, 32'd0);
    chk("reset cart_data", {24'd0, cart_data}, 32'd0);

`ifndef CART_PREFETCH_EN
    // Single cart read, ack three cycles after mem_req.
    step(); cart_req = 1'b1; cart_addr = 25'h001234;
    step(); cart_req = 1'b0; peek();
    chk("t1 mem_req", {31'd0, mem_req}, 32'd1);
    chk("t1 mem_addr", {7'd0, mem_addr}, 32'h001234);
    chk("t1 mem_we", {31'd0, mem_we}, 32'd0);
    step(); step(); step(); mem_ack = 1'b1; mem_rdata = 8'hA5; peek();
    chk("t1 valid early", {31'd0, cart_valid}, 32'd0);
    step(); mem_ack = 1'b0; peek();
    chk("t1 cart_valid", {31'd0, cart_valid}, 32'd1);
    chk("t1 cart_data", {24'd0, cart_data}, 32'hA5);
    chk("t1 busy after", {31'd0, busy}, 32'd0);
    step(); peek();
    chk("t1 valid pulse", {31'd0, cart_valid}, 32'd0);

    // Loader write, cart request arrives during it.
    step(); ldr_req = 1'b1; ldr_addr = 25'h10; ldr_wdata = 8'h5A;
    step(); cart_req = 1'b1; cart_addr = 25'h777; peek();
    chk("t2 ldr mem_we", {31'd0, mem_we}, 32'd1);
    chk("t2 ldr mem_addr", {7'd0, mem_addr}, 32'h10);
    chk("t2 ldr mem_wdata", {24'd0, mem_wdata}, 32'h5A);
    step(); cart_req = 1'b0; mem_ack = 1'b1;
    step(); mem_ack = 1'b0; ldr_req = 1'b0; peek();
    chk("t2 ldr_ack", {31'd0, ldr_ack}, 32'd1);
    chk("t2 idle gap", {31'd0, busy}, 32'd0);
    step(); peek();
    chk("t2 cart mem_addr", {7'd0, mem_addr}, 32'h777);
    chk("t2 cart mem_req", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 8'h3C;
    step(); mem_ack = 1'b0; peek();
    chk("t2 cart_data", {24'd0, cart_data}, 32'h3C);
    chk("t2 overrun", {31'd0, cart_overrun}, 32'd0);

    // Two cart requests during a save write: latest wins, overrun sticks.
    step(); save_req = 1'b1; save_we = 1'b1; save_addr = 25'h50; save_wdata = 8'h11;
    step(); cart_req = 1'b1; cart_addr = 25'h100; peek();
    chk("t3 save mem_addr", {7'd0, mem_addr}, 32'h50);
    step(); cart_addr = 25'h200;
    step(); cart_req = 1'b0; mem_ack = 1'b1; mem_rdata = 8'hEE;
    step(); mem_ack = 1'b0; save_req = 1'b0; peek();
    chk("t3 save_ack", {31'd0, save_ack}, 32'd1);
    chk("t3 overrun", {31'd0, cart_overrun}, 32'd1);
    chk("t3 save_rdata kept", {24'd0, save_rdata}, 32'h00);
    step(); peek();
    chk("t3 cart mem_addr", {7'd0, mem_addr}, 32'h200);
    mem_ack = 1'b1; mem_rdata = 8'h42;
    step(); mem_ack = 1'b0; peek();
    chk("t3 cart_data", {24'd0, cart_data}, 32'h42);
    step(); step(); step(); peek();
    chk("t3 single read", {31'd0, mem_req}, 32'd0);

    // Save read timeout, then a stray ack in IDLE.
    step(); save_req = 1'b1; save_we = 1'b0; save_addr = 25'h60;
    repeat (TIMEOUT) step();
    peek();
    chk("t4 still waiting", {31'd0, mem_req}, 32'd1);
    step(); save_req = 1'b0; peek();
    chk("t4 save_ack", {31'd0, save_ack}, 32'd1);
    chk("t4 save_rdata", {24'd0, save_rdata}, 32'hFF);
    chk("t4 mem_req dropped", {31'd0, mem_req}, 32'd0);
    step(); mem_ack = 1'b1; mem_rdata = 8'h00;
    step(); mem_ack = 1'b0; peek();
    chk("t4 stray busy", {31'd0, busy}, 32'd0);
    chk("t4 stray save_ack", {31'd0, save_ack}, 32'd0);
    chk("t4 stray rdata", {24'd0, save_rdata}, 32'hFF);

    // Reset while the loader is waiting.
    step(); ldr_req = 1'b1; ldr_addr = 25'h20; ldr_wdata = 8'h77;
    step(); peek();
    chk("t5 granted", {31'd0, mem_req}, 32'd1);
    step(); reset = 1'b1;
    step(); reset = 1'b0; peek();
    chk("t5 mem_req", {31'd0, mem_req}, 32'd0);
    chk("t5 busy", {31'd0, busy}, 32'd0);
    chk("t5 ldr_ack", {31'd0, ldr_ack}, 32'd0);
    chk("t5 overrun cleared", {31'd0, cart_overrun}, 32'd0);
    step(); peek();
    chk("t5 regrant addr", {7'd0, mem_addr}, 32'h20);
    chk("t5 regrant we", {31'd0, mem_we}, 32'd1);
    mem_ack = 1'b1;
    step(); mem_ack = 1'b0; ldr_req = 1'b0; peek();
    chk("t5 ldr_ack", {31'd0, ldr_ack}, 32'd1);

    // Loader beats save when both are requesting.
    step(); ldr_req = 1'b1; ldr_addr = 25'h30; ldr_wdata = 8'h01;
    save_req = 1'b1; save_we = 1'b0; save_addr = 25'h1FFFFFF;
    step(); peek();
    chk("t6 ldr first", {7'd0, mem_addr}, 32'h30);
    mem_ack = 1'b1;
    step(); mem_ack = 1'b0; ldr_req = 1'b0; peek();
    chk("t6 ldr_ack", {31'd0, ldr_ack}, 32'd1);
    chk("t6 no save_ack", {31'd0, save_ack}, 32'd0);
    step(); peek();
    chk("t6 save addr", {7'd0, mem_addr}, 32'h1FFFFFF);
    mem_ack = 1'b1; mem_rdata = 8'h99;
    step(); mem_ack = 1'b0; save_req = 1'b0; peek();
    chk("t6 save_rdata", {24'd0, save_rdata}, 32'h99);
    step(); step();
`else
    // Prefetch: 0x400 read fills the cache with 0x401.
    step(); cart_req = 1'b1; cart_addr = 25'h400;
    step(); cart_req = 1'b0; peek();
    chk("pf first addr", {7'd0, mem_addr}, 32'h400);
    mem_ack = 1'b1; mem_rdata = 8'h10;
    step(); mem_ack = 1'b0; peek();
    chk("pf first data", {24'd0, cart_data}, 32'h10);
    step(); peek();
    chk("pf fetch addr", {7'd0, mem_addr}, 32'h401);
    chk("pf fetch req", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 8'h20;
    step(); mem_ack = 1'b0; cart_req = 1'b1; cart_addr = 25'h401;
    step(); cart_req = 1'b0; peek();
    chk("pf hit valid", {31'd0, cart_valid}, 32'd1);
    chk("pf hit data", {24'd0, cart_data}, 32'h20);
    chk("pf hit no mem", {31'd0, mem_req}, 32'd0);
    step(); peek();
    chk("pf hit idle", {31'd0, busy}, 32'd0);
    ldr_req = 1'b1; ldr_addr = 25'h401; ldr_wdata = 8'h55;
    step(); peek();
    chk("pf ldr addr", {7'd0, mem_addr}, 32'h401);
    mem_ack = 1'b1;
    step(); mem_ack = 1'b0; ldr_req = 1'b0; peek();
    chk("pf ldr_ack", {31'd0, ldr_ack}, 32'd1);
    cart_req = 1'b1; cart_addr = 25'h401;
    step(); cart_req = 1'b0; peek();
    chk("pf miss req", {31'd0, mem_req}, 32'd1);
    chk("pf miss addr", {7'd0, mem_addr}, 32'h401);
    chk("pf miss no valid", {31'd0, cart_valid}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 8'h55;
    step(); mem_ack = 1'b0; peek();
    chk("pf miss data", {24'd0, cart_data}, 32'h55);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
